// File: rtl/lpif_dstrm_flit_packer.sv
// Packs pairs of same-protid 32-bit link-layer beats into 64-bit flit pairs for the LPIF master.
// A lone held beat is flushed as a single flit on timeout, protid change or loss of tx_online.
module lpif_dstrm_flit_packer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk_wr,
  input  logic        rst_wr_n,
  input  logic        tx_online,
  input  logic [7:0]  flush_timeout,
  input  logic [7:0]  lp_state,
  input  logic [3:0]  lp_protid,
  input  logic [31:0] lp_data,
  input  logic        lp_crc,
  input  logic        lp_crc_valid,
  input  logic        lp_valid,
  output logic        lp_ready,
  output logic [7:0]  dstrm_state,
  output logic [3:0]  dstrm_protid,
  output logic [63:0] dstrm_data,
  output logic [1:0]  dstrm_dvalid,
  output logic [1:0]  dstrm_crc,
  output logic [1:0]  dstrm_crc_valid,
  output logic [1:0]  dstrm_valid,
  output logic [31:0] packer_debug_status
);

  typedef enum logic [0:0] {IDLE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] hold_data, hold_data_nxt;
  logic [3:0]  hold_protid, hold_protid_nxt;
  logic        hold_crc, hold_crc_nxt;
  logic        hold_crc_valid, hold_crc_valid_nxt;
  logic [7:0]  cnt, cnt_nxt;

  logic        accept;
  logic        emit_pair;
  logic        emit_single;
  logic [31:0] sgl_data;
  logic [3:0]  sgl_protid;
  logic        sgl_crc;
  logic        sgl_crc_valid;
  logic        timed_out;

  logic [CNT_W-1:0] pair_cnt;
  logic [CNT_W-1:0] single_cnt;

  assign lp_ready = tx_online;
  assign accept   = lp_valid & tx_online;

  // Greater-or-equal so a shrinking flush_timeout flushes on the next idle cycle;
  // a timeout of 0 seen while holding also flushes immediately.
  assign timed_out = ({1'b0, cnt} + 9'd1) >= {1'b0, flush_timeout};

  always_comb begin
    state_nxt          = state;
    hold_data_nxt      = hold_data;
    hold_protid_nxt    = hold_protid;
    hold_crc_nxt       = hold_crc;
    hold_crc_valid_nxt = hold_crc_valid;
    cnt_nxt            = cnt;
    emit_pair          = 1'b0;
    emit_single        = 1'b0;
    sgl_data           = hold_data;
    sgl_protid         = hold_protid;
    sgl_crc            = hold_crc;
    sgl_crc_valid      = hold_crc_valid;

    case (state)
      IDLE: begin
        if (accept) begin
          if (flush_timeout == 8'd0) begin
            emit_single   = 1'b1;
            sgl_data      = lp_data;
            sgl_protid    = lp_protid;
            sgl_crc       = lp_crc;
            sgl_crc_valid = lp_crc_valid;
          end else begin
            hold_data_nxt      = lp_data;
            hold_protid_nxt    = lp_protid;
            hold_crc_nxt       = lp_crc;
            hold_crc_valid_nxt = lp_crc_valid;
            cnt_nxt            = '0;
            state_nxt          = HOLD;
          end
        end
      end
      HOLD: begin
        if (!tx_online) begin
          emit_single = 1'b1;
          state_nxt   = IDLE;
        end else if (accept && (lp_protid == hold_protid)) begin
          emit_pair = 1'b1;
          state_nxt = IDLE;
        end else if (accept) begin
          emit_single        = 1'b1;
          hold_data_nxt      = lp_data;
          hold_protid_nxt    = lp_protid;
          hold_crc_nxt       = lp_crc;
          hold_crc_valid_nxt = lp_crc_valid;
          cnt_nxt            = '0;
        end else if (timed_out) begin
          emit_single = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state          <= IDLE;
      hold_data      <= '0;
      hold_protid    <= '0;
      hold_crc       <= 1'b0;
      hold_crc_valid <= 1'b0;
      cnt            <= '0;
    end else begin
      state          <= state_nxt;
      hold_data      <= hold_data_nxt;
      hold_protid    <= hold_protid_nxt;
      hold_crc       <= hold_crc_nxt;
      hold_crc_valid <= hold_crc_valid_nxt;
      cnt            <= cnt_nxt;
    end
  end

  // Output register: data/crc/protid keep their last value when no flit is loaded.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      dstrm_state     <= '0;
      dstrm_protid    <= '0;
      dstrm_data      <= '0;
      dstrm_dvalid    <= '0;
      dstrm_crc       <= '0;
      dstrm_crc_valid <= '0;
    end else begin
      dstrm_state <= lp_state;
      if (emit_pair) begin
        dstrm_data      <= {lp_data, hold_data};
        dstrm_protid    <= hold_protid;
        dstrm_dvalid    <= 2'b11;
        dstrm_crc       <= {lp_crc, hold_crc};
        dstrm_crc_valid <= {lp_crc_valid, hold_crc_valid};
      end else if (emit_single) begin
        dstrm_data      <= {32'd0, sgl_data};
        dstrm_protid    <= sgl_protid;
        dstrm_dvalid    <= 2'b01;
        dstrm_crc       <= {1'b0, sgl_crc};
        dstrm_crc_valid <= {1'b0, sgl_crc_valid};
      end else begin
        dstrm_dvalid    <= '0;
        dstrm_crc_valid <= '0;
      end
    end
  end

  assign dstrm_valid = dstrm_dvalid;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      pair_cnt   <= '0;
      single_cnt <= '0;
    end else begin
      if (emit_pair && (pair_cnt != '1)) begin
        pair_cnt <= pair_cnt + 1'b1;
      end
      if (emit_single && (single_cnt != '1)) begin
        single_cnt <= single_cnt + 1'b1;
      end
    end
  end

  assign packer_debug_status = {single_cnt, pair_cnt};

endmodule

// File: tb/tb_lpif_dstrm_flit_packer.sv
// Scoreboard bench for lpif_dstrm_flit_packer: expected flits (with their visible cycle)
// are queued as beats are driven and matched against the output register at negedge.
module tb_lpif_dstrm_flit_packer;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n;
  logic        tx_online;
  logic [7:0]  flush_timeout;
  logic [7:0]  lp_state;
  logic [3:0]  lp_protid;
  logic [31:0] lp_data;
  logic        lp_crc;
  logic        lp_crc_valid;
  logic        lp_valid;
  logic        lp_ready;
  logic [7:0]  dstrm_state;
  logic [3:0]  dstrm_protid;
  logic [63:0] dstrm_data;
  logic [1:0]  dstrm_dvalid;
  logic [1:0]  dstrm_crc;
  logic [1:0]  dstrm_crc_valid;
  logic [1:0]  dstrm_valid;
  logic [31:0] packer_debug_status;

  lpif_dstrm_flit_packer #(.CNT_W(16)) dut (
    .clk_wr              (clk_wr),
    .rst_wr_n            (rst_wr_n),
    .tx_online           (tx_online),
    .flush_timeout       (flush_timeout),
    .lp_state            (lp_state),
    .lp_protid           (lp_protid),
    .lp_data             (lp_data),
    .lp_crc              (lp_crc),
    .lp_crc_valid        (lp_crc_valid),
    .lp_valid            (lp_valid),
    .lp_ready            (lp_ready),
    .dstrm_state         (dstrm_state),
    .dstrm_protid        (dstrm_protid),
    .dstrm_data          (dstrm_data),
    .dstrm_dvalid        (dstrm_dvalid),
    .dstrm_crc           (dstrm_crc),
    .dstrm_crc_valid     (dstrm_crc_valid),
    .dstrm_valid         (dstrm_valid),
    .packer_debug_status (packer_debug_status)
  );

  always #5 clk_wr = ~clk_wr;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic [3:0]  protid;
    logic [1:0]  dv;
    logic [1:0]  crc;
    logic [1:0]  cv;
  } flit_t;

  flit_t q[$];
  flit_t e;
  int    cyc = 0;
  int    n_total = 0;
  int    n_bad = 0;

  always @(posedge clk_wr) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_flit(input int c, input logic [63:0] d, input logic [3:0] p,
                          input logic [1:0] dv, input logic [1:0] crc, input logic [1:0] cv);
    flit_t f;
    f.cyc = c; f.data = d; f.protid = p; f.dv = dv; f.crc = crc; f.cv = cv;
    q.push_back(f);
  endtask

  task automatic beat(input logic [3:0] p, input logic [31:0] d, input logic c, input logic cv);
    lp_valid = 1'b1; lp_protid = p; lp_data = d; lp_crc = c; lp_crc_valid = cv;
    @(posedge clk_wr); #1;
    lp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_wr); #1;
    end
  endtask

  always @(negedge clk_wr) begin
    if (rst_wr_n) begin
      if (dstrm_dvalid != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_flit", 64'(dstrm_dvalid), 64'(0));
        end else begin
          e = q.pop_front();
          chk("flit_cycle", 64'(cyc), 64'(e.cyc));
          chk("flit_data", dstrm_data, e.data);
          chk("flit_protid", 64'(dstrm_protid), 64'(e.protid));
          chk("flit_dvalid", 64'(dstrm_dvalid), 64'(e.dv));
          chk("flit_valid", 64'(dstrm_valid), 64'(e.dv));
          chk("flit_crc", 64'(dstrm_crc), 64'(e.crc));
          chk("flit_crc_valid", 64'(dstrm_crc_valid), 64'(e.cv));
        end
      end else begin
        if (dstrm_valid != 2'b00 || dstrm_crc_valid != 2'b00)
          chk("idle_valids", 64'({dstrm_valid, dstrm_crc_valid}), 64'(0));
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          chk("flit_missing", 64'(dstrm_dvalid), 64'(e.dv));
        end
      end
    end
  end

  int k;

  initial begin
    rst_wr_n = 1'b0; tx_online = 1'b0; flush_timeout = 8'd3; lp_state = 8'h00;
    lp_protid = '0; lp_data = '0; lp_crc = 1'b0; lp_crc_valid = 1'b0; lp_valid = 1'b0;
    #12;
    chk("rst_dvalid", 64'(dstrm_dvalid), 64'(0));
    chk("rst_data", dstrm_data, 64'(0));
    chk("rst_status", 64'(packer_debug_status), 64'(0));
    chk("rst_state", 64'(dstrm_state), 64'(0));
    chk("rst_ready", 64'(lp_ready), 64'(0));
    @(posedge clk_wr); #1;
    rst_wr_n = 1'b1; tx_online = 1'b1; lp_state = 8'h5A;
    #1;
    chk("ready_online", 64'(lp_ready), 64'(1));
    chk("state_before_edge", 64'(dstrm_state), 64'(0));
    idle(1);
    chk("state_after_edge", 64'(dstrm_state), 64'(8'h5A));

    // back-to-back same-protid pair
    k = cyc;
    exp_flit(k + 2, 64'hA5A5_0002_A5A5_0001, 4'd3, 2'b11, 2'b01, 2'b11);
    beat(4'd3, 32'hA5A5_0001, 1'b1, 1'b1);
    beat(4'd3, 32'hA5A5_0002, 1'b0, 1'b1);
    idle(3);
    chk("pairs_t1", 64'(packer_debug_status[15:0]), 64'(1));

    // lone beat flushed by timeout
    k = cyc;
    exp_flit(k + 4, 64'h0000_0000_0000_1234, 4'd5, 2'b01, 2'b01, 2'b01);
    beat(4'd5, 32'h0000_1234, 1'b1, 1'b1);
    idle(6);
    chk("singles_t2", 64'(packer_debug_status[31:16]), 64'(1));

    // protid change then timeout
    flush_timeout = 8'd2;
    k = cyc;
    exp_flit(k + 2, 64'h0000_0000_CAFE_0001, 4'd1, 2'b01, 2'b00, 2'b00);
    exp_flit(k + 4, 64'h0000_0000_CAFE_0002, 4'd2, 2'b01, 2'b01, 2'b01);
    beat(4'd1, 32'hCAFE_0001, 1'b0, 1'b0);
    beat(4'd2, 32'hCAFE_0002, 1'b1, 1'b1);
    idle(5);
    chk("singles_t3", 64'(packer_debug_status[31:16]), 64'(3));

    // beat arriving in the timeout cycle still pairs
    k = cyc;
    exp_flit(k + 3, 64'h6666_0002_6666_0001, 4'd6, 2'b11, 2'b00, 2'b11);
    beat(4'd6, 32'h6666_0001, 1'b0, 1'b1);
    idle(1);
    beat(4'd6, 32'h6666_0002, 1'b0, 1'b1);
    idle(4);
    chk("pairs_t4", 64'(packer_debug_status[15:0]), 64'(2));

    // flush_timeout lowered below the running count
    flush_timeout = 8'd8;
    k = cyc;
    exp_flit(k + 5, 64'h0000_0000_9999_0001, 4'd9, 2'b01, 2'b00, 2'b01);
    beat(4'd9, 32'h9999_0001, 1'b0, 1'b1);
    idle(3);
    flush_timeout = 8'd2;
    idle(4);
    chk("singles_t5", 64'(packer_debug_status[31:16]), 64'(4));

    // tx_online drop while holding
    flush_timeout = 8'd10;
    k = cyc;
    exp_flit(k + 2, 64'h0000_0000_0BAD_F00D, 4'd7, 2'b01, 2'b01, 2'b01);
    beat(4'd7, 32'h0BAD_F00D, 1'b1, 1'b1);
    tx_online = 1'b0;
    lp_valid = 1'b1; lp_protid = 4'd7; lp_data = 32'hFFFF_0000;
    #1;
    chk("ready_offline", 64'(lp_ready), 64'(0));
    idle(12);
    lp_valid = 1'b0; tx_online = 1'b1;
    idle(1);
    chk("singles_t6", 64'(packer_debug_status[31:16]), 64'(5));

    // reset while holding discards the beat
    flush_timeout = 8'd20;
    beat(4'd8, 32'hDEAD_0001, 1'b1, 1'b1);
    idle(2);
    rst_wr_n = 1'b0;
    #1;
    chk("midrst_dvalid", 64'(dstrm_dvalid), 64'(0));
    chk("midrst_data", dstrm_data, 64'(0));
    chk("midrst_protid", 64'(dstrm_protid), 64'(0));
    chk("midrst_crc_valid", 64'(dstrm_crc_valid), 64'(0));
    chk("midrst_status", 64'(packer_debug_status), 64'(0));
    chk("midrst_state", 64'(dstrm_state), 64'(0));
    @(posedge clk_wr); #1;
    rst_wr_n = 1'b1;
    idle(25);
    k = cyc;
    exp_flit(k + 2, 64'hDEAD_0003_DEAD_0002, 4'd8, 2'b11, 2'b00, 2'b11);
    beat(4'd8, 32'hDEAD_0002, 1'b0, 1'b1);
    beat(4'd8, 32'hDEAD_0003, 1'b0, 1'b1);
    idle(2);
    chk("status_t7", 64'(packer_debug_status), 64'(32'h0000_0001));

    // packing disabled: every beat is an immediate single
    flush_timeout = 8'd0;
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      exp_flit(k + 1 + i, 64'(32'h4000_0000 + 32'(i)), 4'd4, 2'b01, {1'b0, i[0]}, 2'b01);
    end
    for (int i = 0; i < 4; i++) begin
      beat(4'd4, 32'h4000_0000 + 32'(i), i[0], 1'b1);
    end
    idle(3);
    chk("status_t8", 64'(packer_debug_status), 64'(32'h0004_0001));

    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
